// File: rtl/coin_acceptor.sv
// Coin sensor front end for the vend FSM: synchronise and debounce the nickel/dime sensors,
// then present one 2-bit coin code at a time to vend, with one pending slot and jam/overflow reject.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             nickel_sense,
    input  logic             dime_sense,
    input  logic             newspaper,
    output logic [1:0]       coin,
    output logic             coin_reject,
    output logic [CNT_W-1:0] coin_count
);

    localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] CODE_NONE   = 2'b00;
    localparam logic [1:0] CODE_NICKEL = 2'b01;
    localparam logic [1:0] CODE_DIME   = 2'b10;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_HELD,
        SLOT_FULL
    } slot_t;

    // Channel index 0 is the nickel sensor, index 1 the dime sensor.
    logic [1:0]      sense;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      rise;
    logic [DB_W-1:0] db_cnt [2];

    slot_t           state_q;
    slot_t           state_d;
    logic [1:0]      coin_d;
    logic [1:0]      pend_q;
    logic [1:0]      pend_d;
    logic            reject_d;
    logic [CNT_W-1:0] count_d;

    logic            jam;
    logic            single;
    logic            consume;
    logic [1:0]      ev_code;

    assign sense = {dime_sense, nickel_sense};

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            rise  <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= sense;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                rise[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    // Level accepted; only a rising acceptance counts as a coin.
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                    rise[i]   <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign jam     = rise[0] & rise[1];
    assign single  = rise[0] ^ rise[1];
    assign ev_code = rise[0] ? CODE_NICKEL : CODE_DIME;
    assign consume = (state_q != SLOT_EMPTY) && !newspaper;

    always_comb begin
        state_d  = state_q;
        coin_d   = coin;
        pend_d   = pend_q;
        reject_d = 1'b0;
        count_d  = coin_count;

        if (consume) begin
            count_d = coin_count + 1'b1;
        end

        case (state_q)
            SLOT_EMPTY: begin
                if (single) begin
                    coin_d  = ev_code;
                    state_d = SLOT_HELD;
                end
            end
            SLOT_HELD: begin
                if (consume) begin
                    if (single) begin
                        coin_d = ev_code;
                    end else begin
                        coin_d  = CODE_NONE;
                        state_d = SLOT_EMPTY;
                    end
                end else if (single) begin
                    pend_d  = ev_code;
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                // Pending coin always moves ahead of a same-cycle event to keep FIFO order.
                if (consume) begin
                    coin_d = pend_q;
                    if (single) begin
                        pend_d = ev_code;
                    end else begin
                        pend_d  = CODE_NONE;
                        state_d = SLOT_HELD;
                    end
                end else if (single) begin
                    reject_d = 1'b1;
                end
            end
            default: begin
                coin_d  = CODE_NONE;
                pend_d  = CODE_NONE;
                state_d = SLOT_EMPTY;
            end
        endcase

        if (jam) begin
            reject_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= SLOT_EMPTY;
            coin        <= CODE_NONE;
            pend_q      <= CODE_NONE;
            coin_reject <= 1'b0;
            coin_count  <= '0;
        end else begin
            state_q     <= state_d;
            coin        <= coin_d;
            pend_q      <= pend_d;
            coin_reject <= reject_d;
            coin_count  <= count_d;
        end
    end

endmodule
